writeback_arbiter: RTL
======================

# writeback_arbiter

Shares the single register-file write port between several writeback sources (ALU, load unit, CSR unit) using round-robin arbitration with valid/ready handshakes. Accepted writes are registered one cycle and then driven onto the register file's `rdAddress`/`rd`/`writeEnable` write interface. A 32-entry busy scoreboard tracks registers with an outstanding producer, so issue logic can stall on `rs1`/`rs2` hazards.

## Interface
- NUM_SOURCES, 3: number of writeback requesters, 2..8.
- XLEN, 32: data width.
- clock  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- srcValid  in  NUM_SOURCES  per-source write request.
- srcReady  out  NUM_SOURCES  per-source grant; one-hot or zero.
- srcAddress  in  NUM_SOURCES×5  packed destination register; source i occupies bits [5i+4:5i].
- srcData  in  NUM_SOURCES×XLEN  packed write data, same packing as `srcAddress`.
- issueValid  in  1  marks `issueAddress` as having an outstanding producer.
- issueAddress  in  5  destination register of the issued instruction.
- rs1Address, rs2Address  in  5 each  scoreboard lookup addresses.
- rs1Busy, rs2Busy  out  1 each  combinational busy bit for each lookup address.
- rdAddress  out  5  register-file write address (registered).
- rd  out  XLEN  register-file write data (registered).
- writeEnable  out  1  register-file write strobe (registered).

## Operation
- **Grant.** Search `srcValid` starting at pointer `ptr` and moving upward with wrap-around. The first valid source gets `srcReady`=1; all others get 0. No valid source means `srcReady`=0.
- **Handshake.** A transfer occurs when `srcValid[i]` and `srcReady[i]` are both 1. A source must hold valid, address and data stable until the transfer. `srcValid` must not depend on `srcReady`.
- **Pointer.** After a transfer from source g, `ptr` becomes (g+1) mod NUM_SOURCES. With no transfer, `ptr` is unchanged.
- **Output register, transfer to a nonzero address.** The next edge loads `rdAddress`, `rd` and `writeEnable`=1.
- **Output register, transfer to x0.** The transfer is still accepted and `ptr` still advances, but `writeEnable`=0 and the scoreboard is untouched.
- **Output register, no transfer.** The next edge loads `writeEnable`=0; `rdAddress` and `rd` hold their values.
- **Scoreboard.** Holds `busy[31:0]`; `busy[0]` is hard-wired to 0.
  - A clock edge with `issueValid`=1 and `issueAddress`≠0 sets the bit.
  - A clock edge with `writeEnable`=1 clears `busy[rdAddress]`. This is the same edge at which the register file commits, so the data is visible exactly when busy drops.
  - Set and clear on the same address in the same edge: set wins, because a newer producer is now outstanding.
  - Writeback to a register that is not busy is legal; the bit stays 0.
- **Lookup.** `rs1Busy` = `busy[rs1Address]`; `rs2Busy` = `busy[rs2Address]`. Purely combinational, with no bypass of in-flight writes.
- **Reset (`reset`=0).** Asynchronously forces:
  - `writeEnable`=0, `rdAddress`=0, `rd`=0;
  - `ptr`=0 and all `busy` bits 0;
  - `srcReady`=0 while reset is held.
  - A write captured before reset is discarded and its source must re-request.

## Timing
- Handshake in cycle n → `writeEnable` high in cycle n+1 → register file updated at the end of cycle n+1. `busy` clears at that same edge.
- Throughput: one write per cycle. A continuously valid source gets at least 1 grant per NUM_SOURCES cycles.
- `issueValid` in cycle n → busy bit visible on `rs1Busy`/`rs2Busy` in cycle n+1.
- `srcReady` is combinational from `srcValid` and `ptr`. `rd`, `rdAddress` and `writeEnable` have no combinational path from the inputs.

## Structure
- Shared package `regfile_pkg`:
  - constants `XLEN`=32, `REG_ADDR_WIDTH`=5, `NUM_REGS`=32;
  - typedefs `reg_addr_t` (logic [4:0]) and `word_t` (logic [XLEN-1:0]).
  - The register file and this block both import it.
- Sub-module `rr_arbiter`:
  - parameter NUM_SOURCES;
  - inputs: request vector, transfer strobe;
  - holds `ptr`; outputs a one-hot grant and the granted index.
  - The scoreboard and output register live in the top module.

## Test plan
- **Reset.** Hold `reset`=0 with all sources valid → `srcReady`=0, `writeEnable`=0, `rs1Busy`=0 for every address. Release → source 0 is granted first.
- **Round-robin fairness.** NUM_SOURCES=3, all sources valid for 6 cycles with addresses 1/2/3 and data 0xA/0xB/0xC → grant order 0,1,2,0,1,2. The write port shows `rdAddress` 1,2,3,… one cycle after each grant.
- **x0 filtering.** Source 1 writes address 0, data 0xDEADBEEF → `srcReady[1]`=1, `writeEnable` stays 0, `ptr` advances to 2.
- **Scoreboard lifecycle.**
  - `issueValid` with address 5 → `rs1Busy`=1 for `rs1Address`=5 in the following cycle.
  - Source 0 then writes address 5 with data 0x1234 → `busy` clears at the `writeEnable` edge, and the register-file readback of x5 = 0x1234 in the same cycle that `rs1Busy` reads 0.
- **Simultaneous set/clear.** `issueValid` with address 7 in the same edge that `writeEnable` commits x7 → `busy[7]`=1 afterwards.
- **Mid-operation reset.** Handshake to address 9 in cycle n, `reset` asserted in cycle n+1 before the edge → `writeEnable` drops immediately, x9 is not written, and `busy[9]` reads 0 after reset.

Source files
------------

// File: rtl/regfile_pkg.sv
// Shared register-file definitions used by the register file and its write-port arbiter.
package regfile_pkg;

    localparam int unsigned XLEN           = 32;
    localparam int unsigned REG_ADDR_WIDTH = 5;
    localparam int unsigned NUM_REGS       = 32;

    typedef logic [REG_ADDR_WIDTH-1:0] reg_addr_t;
    typedef logic [XLEN-1:0]           word_t;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: searches requests upward from a rotating pointer.
// Ports:
//   clk, rst_n     - clock, asynchronous active-low reset
//   i_req          - request vector
//   i_xfer         - a transfer to the granted requester happens this cycle
//   o_grant_c      - one-hot grant (zero when no request), combinational
//   o_grant_idx_c  - index of the granted requester, combinational
module rr_arbiter #(
    parameter  int unsigned NUM_SOURCES = 3,
    localparam int unsigned IDX_W       = $clog2(NUM_SOURCES)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [NUM_SOURCES-1:0] i_req,
    input  logic                   i_xfer,
    output logic [NUM_SOURCES-1:0] o_grant_c,
    output logic [IDX_W-1:0]       o_grant_idx_c
);

    logic [IDX_W-1:0] r_ptr;
    logic [IDX_W-1:0] w_ptr_nxt;
    logic             w_found;
    int unsigned      w_idx;

    // First requester at or above the pointer, wrapping around.
    always_comb begin
        o_grant_c     = '0;
        o_grant_idx_c = '0;
        w_found       = 1'b0;
        w_idx         = 0;
        for (int unsigned k = 0; k < NUM_SOURCES; k++) begin
            w_idx = 32'(r_ptr) + k;
            if (w_idx >= NUM_SOURCES) begin
                w_idx = w_idx - NUM_SOURCES;
            end
            if (!w_found && i_req[IDX_W'(w_idx)]) begin
                w_found                     = 1'b1;
                o_grant_c[IDX_W'(w_idx)]    = 1'b1;
                o_grant_idx_c               = IDX_W'(w_idx);
            end
        end
    end

    // Pointer moves just past the winner so it becomes lowest priority.
    always_comb begin
        w_ptr_nxt = o_grant_idx_c + IDX_W'(1);
        if (o_grant_idx_c == IDX_W'(NUM_SOURCES - 1)) begin
            w_ptr_nxt = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ptr <= '0;
        end else if (i_xfer) begin
            r_ptr <= w_ptr_nxt;
        end
    end

endmodule

// File: rtl/writeback_arbiter.sv
// Shares the register-file write port among several writeback sources and
// tracks registers with an outstanding producer in a busy scoreboard.
// Ports:
//   clock, reset             - clock, asynchronous active-low reset
//   srcValid/srcReady        - per-source request / one-hot grant
//   srcAddress/srcData       - packed per-source destination and data
//   issueValid/issueAddress  - mark a register busy at issue
//   rs1Address/rs2Address    - scoreboard lookups -> rs1Busy/rs2Busy
//   rdAddress/rd/writeEnable - registered register-file write port
module writeback_arbiter
    import regfile_pkg::*;
#(
    parameter int unsigned NUM_SOURCES = 3,
    parameter int unsigned XLEN        = 32
) (
    input  logic                            clock,
    input  logic                            reset,
    input  logic [NUM_SOURCES-1:0]          srcValid,
    output logic [NUM_SOURCES-1:0]          srcReady,
    input  logic [NUM_SOURCES*REG_ADDR_WIDTH-1:0] srcAddress,
    input  logic [NUM_SOURCES*XLEN-1:0]     srcData,
    input  logic                            issueValid,
    input  reg_addr_t                       issueAddress,
    input  reg_addr_t                       rs1Address,
    input  reg_addr_t                       rs2Address,
    output logic                            rs1Busy,
    output logic                            rs2Busy,
    output reg_addr_t                       rdAddress,
    output logic [XLEN-1:0]                 rd,
    output logic                            writeEnable
);

    localparam int unsigned IDX_W = $clog2(NUM_SOURCES);

    logic [NUM_SOURCES-1:0] w_grant;
    logic [IDX_W-1:0]       w_grant_idx;
    logic                   w_xfer;
    logic                   w_commit;
    reg_addr_t              w_sel_addr;
    logic [XLEN-1:0]        w_sel_data;

    logic                   r_we;
    reg_addr_t              r_rd_addr;
    logic [XLEN-1:0]        r_rd_data;
    logic [NUM_REGS-1:0]    r_busy;
    logic [NUM_REGS-1:0]    w_busy_nxt;

    rr_arbiter #(
        .NUM_SOURCES (NUM_SOURCES)
    ) u_rr_arbiter (
        .clk           (clock),
        .rst_n         (reset),
        .i_req         (srcValid),
        .i_xfer        (w_xfer),
        .o_grant_c     (w_grant),
        .o_grant_idx_c (w_grant_idx)
    );

    // Grants are suppressed while reset is held so nothing is accepted then.
    always_comb begin
        srcReady   = reset ? w_grant : '0;
        w_xfer     = |(srcValid & srcReady);
        w_sel_addr = srcAddress[32'(w_grant_idx)*REG_ADDR_WIDTH +: REG_ADDR_WIDTH];
        w_sel_data = srcData[32'(w_grant_idx)*XLEN +: XLEN];
        // Writes to x0 are accepted but never reach the register file.
        w_commit   = w_xfer && (w_sel_addr != '0);
    end

    // Write-port register; address and data hold when nothing is committed.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_we      <= 1'b0;
            r_rd_addr <= '0;
            r_rd_data <= '0;
        end else begin
            r_we <= w_commit;
            if (w_commit) begin
                r_rd_addr <= w_sel_addr;
                r_rd_data <= w_sel_data;
            end
        end
    end

    // Clear on commit, then set on issue so a newer producer wins a tie.
    always_comb begin
        w_busy_nxt = r_busy;
        if (r_we) begin
            w_busy_nxt[r_rd_addr] = 1'b0;
        end
        if (issueValid && (issueAddress != '0)) begin
            w_busy_nxt[issueAddress] = 1'b1;
        end
        w_busy_nxt[0] = 1'b0;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_busy <= '0;
        end else begin
            r_busy <= w_busy_nxt;
        end
    end

    always_comb begin
        rs1Busy     = r_busy[rs1Address];
        rs2Busy     = r_busy[rs2Address];
        rdAddress   = r_rd_addr;
        rd          = r_rd_data;
        writeEnable = r_we;
    end

endmodule
